// File: rtl/audio_pkg.sv
// Shared definitions for the audio receive path: channel encodings,
// pairing-state type and a constant-friendly clog2.
package audio_pkg;

   localparam logic LRC_LEFT  = 1'b0;
   localparam logic LRC_RIGHT = 1'b1;

   typedef enum logic {
      WAIT_L = 1'b0,
      HAVE_L = 1'b1
   } pair_state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and level output.
// Drop/overflow policy is left to the instantiating block.
module audio_sync_fifo
   import audio_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8
) (
   input  logic                  aud_bclk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [clog2(DEPTH):0] level,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_next;
   logic [AW:0]      rd_next;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
   assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

   always_ff @(posedge aud_bclk) begin
      if (do_push && !clr)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Head is preloaded with whatever entry will sit at rd_next; a word being
   // written this cycle into an otherwise empty FIFO is taken straight from wr_data.
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (wr_next != rd_next) begin
            if (do_push && (wr_ptr == rd_next))
               head <= wr_data;
            else
               head <= mem[rd_next[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/audio_rx_framer.sv
// Pairs left/right words from the I2S receiver into stereo frames and queues
// them for the DSP/record path, reporting drops and pairing errors.
//
// state  | meaning
// WAIT_L | no left word held; expecting a left word
// HAVE_L | left word held in left_hold; expecting the matching right word
module audio_rx_framer
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = 24,
   parameter int DEPTH    = 8
) (
   input  logic                  aud_bclk,
   input  logic                  rst_n,
   input  logic                  aud_lrc,
   input  logic                  rx_done,
   input  logic [31:0]           adc_data,
   input  logic                  en,
   input  logic                  clr,
   output logic                  frm_valid,
   output logic [SAMPLE_W-1:0]   frm_left,
   output logic [SAMPLE_W-1:0]   frm_right,
   input  logic                  frm_ready,
   output logic [clog2(DEPTH):0] fifo_level,
   output logic                  overflow,
   output logic [7:0]            sync_err
);

   pair_state_t           state;
   logic                  lrc_d;
   logic                  ch_start;
   logic [SAMPLE_W-1:0]   left_hold;
   logic [SAMPLE_W-1:0]   sample;
   logic                  word;
   logic                  push_req;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [2*SAMPLE_W-1:0] fifo_head;
   logic                  unused_low;

   assign sample     = adc_data[31 -: SAMPLE_W];
   assign unused_low = ^adc_data;
   assign word       = rx_done && en && !clr;
   assign push_req   = word && (state == HAVE_L) && (ch_start == LRC_RIGHT);
   assign pop        = frm_valid && frm_ready;

   // ch_start is the channel in force before this cycle, so a word arriving
   // together with an lrc edge keeps the pre-edge tag.
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         lrc_d    <= 1'b0;
         ch_start <= LRC_LEFT;
      end else begin
         lrc_d <= aud_lrc;
         if (aud_lrc ^ lrc_d)
            ch_start <= aud_lrc;
      end
   end

   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_L;
         left_hold <= '0;
         overflow  <= 1'b0;
         sync_err  <= 8'd0;
      end else if (clr) begin
         state    <= WAIT_L;
         overflow <= 1'b0;
         sync_err <= 8'd0;
      end else if (!en) begin
         state <= WAIT_L;
      end else if (rx_done) begin
         case (state)
            WAIT_L: begin
               if (ch_start == LRC_LEFT) begin
                  left_hold <= sample;
                  state     <= HAVE_L;
               end else if (sync_err != 8'hFF) begin
                  sync_err <= sync_err + 8'd1;
               end
            end
            HAVE_L: begin
               if (ch_start == LRC_RIGHT) begin
                  state <= WAIT_L;
                  if (fifo_full && !pop)
                     overflow <= 1'b1;
               end else begin
                  left_hold <= sample;
                  if (sync_err != 8'hFF)
                     sync_err <= sync_err + 8'd1;
               end
            end
            default: state <= WAIT_L;
         endcase
      end
   end

   audio_sync_fifo #(
      .WIDTH (2*SAMPLE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .aud_bclk (aud_bclk),
      .rst_n    (rst_n),
      .clr      (clr),
      .push     (push_req),
      .wr_data  ({left_hold, sample}),
      .pop      (pop),
      .head     (fifo_head),
      .level    (fifo_level),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign frm_valid = !fifo_empty;
   assign frm_left  = fifo_head[2*SAMPLE_W-1:SAMPLE_W];
   assign frm_right = fifo_head[SAMPLE_W-1:0];

endmodule

// File: tb/tb_audio_rx_framer.sv
// Directed and randomized bench for audio_rx_framer against a queue-based
// frame model.
module tb_audio_rx_framer;

   localparam int SW    = 24;
   localparam int DEPTH = 8;

   logic          aud_bclk = 1'b0;
   logic          rst_n    = 1'b0;
   logic          aud_lrc  = 1'b0;
   logic          rx_done  = 1'b0;
   logic [31:0]   adc_data = 32'd0;
   logic          en       = 1'b1;
   logic          clr      = 1'b0;
   logic          frm_ready = 1'b0;
   logic          frm_valid;
   logic [SW-1:0] frm_left;
   logic [SW-1:0] frm_right;
   logic [3:0]    fifo_level;
   logic          overflow;
   logic [7:0]    sync_err;

   int checks = 0;
   int errors = 0;

   logic [2*SW-1:0] q[$];
   bit              m_pend;
   logic [SW-1:0]   m_held;
   int              m_err;
   bit              m_ovf;
   bit              m_ch;
   bit              m_lrc_prev;
   bit              rnd_rdy;

   always #5 aud_bclk = ~aud_bclk;

   audio_rx_framer #(.SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
      .aud_bclk   (aud_bclk),
      .rst_n      (rst_n),
      .aud_lrc    (aud_lrc),
      .rx_done    (rx_done),
      .adc_data   (adc_data),
      .en         (en),
      .clr        (clr),
      .frm_valid  (frm_valid),
      .frm_left   (frm_left),
      .frm_right  (frm_right),
      .frm_ready  (frm_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .sync_err   (sync_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("frm_valid", 64'(frm_valid), 64'(q.size() != 0));
      chk("fifo_level", 64'(fifo_level), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("sync_err", 64'(sync_err), 64'(m_err));
      if (q.size() != 0) begin
         chk("frm_left", 64'(frm_left), 64'(q[0][2*SW-1:SW]));
         chk("frm_right", 64'(frm_right), 64'(q[0][SW-1:0]));
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pend = 0; m_held = '0; m_err = 0; m_ovf = 0; m_ch = 0; m_lrc_prev = 0;
   endtask

   task automatic bump_err();
      if (m_err != 255) m_err++;
   endtask

   // One bclk cycle: model consumes the inputs present now, then outputs are
   // compared 1 time unit after the rising edge.
   task automatic cycle();
      bit pop, full, do_push;
      logic [SW-1:0] s;
      if (rnd_rdy) frm_ready = 1'($urandom_range(0, 1));
      s       = adc_data[31:32-SW];
      pop     = frm_ready && (q.size() > 0);
      full    = (q.size() == DEPTH);
      do_push = 0;
      if (clr) begin
         q.delete(); m_pend = 0; m_err = 0; m_ovf = 0;
      end else begin
         if (!en) m_pend = 0;
         else if (rx_done) begin
            if (m_ch == 1'b0) begin
               if (m_pend) bump_err();
               m_pend = 1; m_held = s;
            end else if (m_pend) begin
               m_pend = 0;
               if (full && !pop) m_ovf = 1;
               else do_push = 1;
            end else bump_err();
         end
         if (pop) void'(q.pop_front());
         if (do_push) q.push_back({m_held, s});
      end
      if (aud_lrc != m_lrc_prev) m_ch = aud_lrc;
      m_lrc_prev = aud_lrc;
      @(posedge aud_bclk);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send_word(input bit lrc, input logic [31:0] d);
      aud_lrc = lrc; rx_done = 0; cycle();
      adc_data = d; rx_done = 1; cycle();
      rx_done = 0; adc_data = $urandom;
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
      send_word(1'b0, l);
      send_word(1'b1, r);
   endtask

   task automatic do_clear();
      clr = 1; cycle(); clr = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      chk("reset_left", 64'(frm_left), 64'd0);
      chk("reset_right", 64'(frm_right), 64'd0);
      @(posedge aud_bclk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      model_reset();
      rnd_rdy = 0;
      #1;
      do_reset();

      // basic pairing
      frm_ready = 1;
      send_word(1'b0, 32'hABCDEF00);
      send_word(1'b1, 32'h12345600);
      idle(2);

      // two lefts, then right; then lone right
      frm_ready = 0;
      send_word(1'b0, 32'h11111100);
      send_word(1'b0, 32'h22222200);
      send_word(1'b1, 32'h33333300);
      chk("pair_left", 64'(frm_left), 64'h222222);
      chk("pair_right", 64'(frm_right), 64'h333333);
      chk("pair_err1", 64'(sync_err), 64'd1);
      send_word(1'b1, 32'h44444400);
      chk("pair_err2", 64'(sync_err), 64'd2);
      frm_ready = 1; idle(3);

      // overflow: 9 frames into a full FIFO
      do_clear();
      frm_ready = 0;
      for (int i = 0; i < 9; i++) send_frame($urandom, $urandom);
      chk("ovf_level", 64'(fifo_level), 64'd8);
      chk("ovf_flag", 64'(overflow), 64'd1);
      frm_ready = 1; idle(10);

      // 9th push coincides with a pop
      do_clear();
      frm_ready = 0;
      for (int i = 0; i < 8; i++) send_frame($urandom, $urandom);
      send_word(1'b0, 32'hC0FFEE00);
      aud_lrc = 1; cycle();
      adc_data = 32'hBEEF0100; rx_done = 1; frm_ready = 1; cycle();
      rx_done = 0; frm_ready = 0;
      chk("coinc_level", 64'(fifo_level), 64'd8);
      chk("coinc_ovf", 64'(overflow), 64'd0);
      frm_ready = 1; idle(10);

      // rx_done coincides with lrc 0->1 edge: tagged left
      aud_lrc = 0; idle(2);
      aud_lrc = 1; adc_data = 32'h5A5A5A00; rx_done = 1; cycle();
      rx_done = 0;
      frm_ready = 0;
      send_word(1'b1, 32'h6B6B6B00);
      chk("edge_left", 64'(frm_left), 64'h5A5A5A);
      frm_ready = 1; idle(2);

      // clear with 3 frames queued and a left held
      frm_ready = 0;
      for (int i = 0; i < 3; i++) send_frame($urandom, $urandom);
      send_word(1'b1, 32'h77777700);
      send_word(1'b0, 32'h88888800);
      do_clear();
      chk("clr_level", 64'(fifo_level), 64'd0);
      chk("clr_valid", 64'(frm_valid), 64'd0);
      chk("clr_err", 64'(sync_err), 64'd0);
      send_word(1'b1, 32'h99999900);

      // disable for a full frame
      en = 0;
      send_frame(32'hAAAAAA00, 32'hBBBBBB00);
      chk("dis_level", 64'(fifo_level), 64'd0);
      en = 1;
      frm_ready = 1;
      send_frame(32'hCCCCCC00, 32'hDDDDDD00);
      idle(2);

      // reset mid-frame
      frm_ready = 0;
      send_frame($urandom, $urandom);
      send_word(1'b0, 32'hEEEEEE00);
      do_reset();
      send_word(1'b1, 32'hF0F0F000);
      frm_ready = 1;
      send_frame(32'h01020300, 32'h04050600);
      idle(2);

      // random backpressure
      do_clear();
      rnd_rdy = 1;
      for (int i = 0; i < 1000; i++) begin
         send_frame($urandom, $urandom);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      rnd_rdy = 0;
      frm_ready = 1;
      idle(20);
      chk("drain_level", 64'(fifo_level), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_rx_framer.md
# audio_rx_framer

Stereo frame assembler directly downstream of the I2S ADC receiver (`audio_receive`), in the `aud_bclk` domain. It consumes the per-channel `rx_done`/`adc_data` word strobes, tags each word left or right from `aud_lrc`, and pairs each left word with the following right word. Complete frames go into a small first-word-fall-through FIFO, read out through a valid/ready handshake by the DSP and record path. Overflow and L/R pairing errors are reported as status.

## Interface
Parameters:
- `SAMPLE_W`, 24: kept sample width; upper `SAMPLE_W` bits of `adc_data`, range 16–32.
- `DEPTH`, 8: FIFO depth in stereo frames; power of 2, range 2–64.

Ports:
- `aud_bclk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `aud_lrc`  in  1  codec word select; 0 = left, 1 = right.
- `rx_done`  in  1  one-cycle word-complete strobe from the receiver.
- `adc_data`  in  32  received word; valid while `rx_done` = 1.
- `en`  in  1  framer enable; 0 discards words and resets pairing.
- `clr`  in  1  synchronous clear of FIFO, pairing, `overflow` and `sync_err`.
- `frm_valid`  out  1  FIFO non-empty.
- `frm_left`  out  SAMPLE_W  left sample of the head frame.
- `frm_right`  out  SAMPLE_W  right sample of the head frame.
- `frm_ready`  in  1  consumer accepts the head frame when `frm_valid` & `frm_ready`.
- `fifo_level`  out  clog2(DEPTH)+1  frames stored, 0..DEPTH.
- `overflow`  out  1  sticky; a frame was dropped because the FIFO was full.
- `sync_err`  out  8  saturating count of pairing errors.

## Operation
- **Channel tag.** `lrc_d` is `aud_lrc` registered. An edge is `aud_lrc ^ lrc_d`; on each edge, `ch_start` <= `aud_lrc`. A word's channel is the `ch_start` value held before the `rx_done` cycle. If an edge and `rx_done` fall in the same cycle, the old (pre-edge) `ch_start` is used.
- **Sample extraction.** `sample = adc_data[31 -: SAMPLE_W]`. No rounding, no sign change.
- **Pairing FSM.** Two states, `WAIT_L` and `HAVE_L`; both apply only when `rx_done` & `en` & !`clr`.
  - `WAIT_L`, left word: latch `left_hold`, go to `HAVE_L`.
  - `WAIT_L`, right word: discard it, `sync_err`+1, stay.
  - `HAVE_L`, right word: push {`left_hold`, sample} to the FIFO, go to `WAIT_L`.
  - `HAVE_L`, left word: overwrite `left_hold`, `sync_err`+1, stay.
- **Disable.** `en` = 0 forces `WAIT_L` and ignores `rx_done`. FIFO contents and the read side are unaffected.
- **FIFO write.**
  - Push when not full.
  - Push when full with no pop in the same cycle: frame dropped, `overflow` <= 1.
  - Push when full with a pop in the same cycle: both happen, level stays DEPTH, no overflow.
- **FIFO read.** Pop on `frm_valid` & `frm_ready`. `frm_left`/`frm_right` show the head frame and are held stable while `frm_valid` = 1 and no pop occurs.
  - Pop when empty: ignored.
  - Push and pop together when empty: no bypass; the frame appears the following cycle.
- **Pointers.** Write and read pointers are clog2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal.
- **`sync_err`.** Saturates at 255.
- **Clear.** `clr` takes priority over every event in the same cycle. It sets pointers to 0, state to `WAIT_L`, `overflow` to 0 and `sync_err` to 0.

## Timing
- Reset values: `frm_valid` 0, `frm_left` 0, `frm_right` 0, `fifo_level` 0, `overflow` 0, `sync_err` 0. Internal state: `WAIT_L`, `ch_start` 0, `lrc_d` 0.
- Latency: a right `rx_done` sampled at edge N writes the frame at edge N; `frm_valid` and `fifo_level` update after edge N (1 bclk).
- Pop at edge M: the next head frame (or `frm_valid` = 0) appears after edge M.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-frame: a held left word is lost and the FIFO empties. After release, pairing restarts at `WAIT_L`.

## Structure
- Package `audio_pkg`:
  - `LRC_LEFT` = 1'b0 and `LRC_RIGHT` = 1'b1.
  - FSM state typedef (`WAIT_L`, `HAVE_L`).
  - Shared `clog2` function.
- Sub-module `audio_sync_fifo`:
  - Parameterised by width (2·SAMPLE_W) and DEPTH.
  - FWFT with registered head, level output, and full/empty flags.
  - No overflow logic inside; the framer owns drop and flag policy.

## Test plan
- Normal pairing: reset, then L=0xABCDEF00 at lrc=0 and R=0x12345600 at lrc=1, `frm_ready`=1 → one frame L=0xABCDEF, R=0x123456, `frm_valid` high exactly 1 cycle after the right `rx_done`.
- Pairing errors: two consecutive lefts (0x111111, 0x222222), then right 0x333333 → single frame {0x222222, 0x333333}, `sync_err`=1. A leading lone right → discarded, `sync_err`=2.
- Overflow: DEPTH=8, `frm_ready`=0, 9 frames → `fifo_level`=8, `overflow`=1, reads return frames 1–8 in order. Repeat with a pop coinciding with the 9th push → no overflow, frame 9 retained.
- Edge coincidence: `rx_done` in the same cycle as an lrc edge 0→1 → word tagged left.
- Clear/disable: `clr` with 3 frames queued and `HAVE_L` → level 0, `frm_valid` 0, `sync_err` 0. `en`=0 for a full frame → no push. Reset asserted mid-frame → all outputs return to reset values.
- Backpressure: random `frm_ready` over 1000 frames against a scoreboard → no loss, no reorder, outputs stable while stalled.
